// File: rtl/bit_serial_subtractor_module.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_subtractor_module
// Description : Multi-cycle a - b - bin unit. One bit per clock, LSB first,
//               through a single full-subtractor cell. Start/busy/done
//               handshake; result registers hold between operations.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous reset, active-low
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high during the WIDTH shift cycles
//   done   out  1      one-cycle pulse after the result registers update
//   diff   out  WIDTH  a - b - bin modulo 2^WIDTH
//   bout   out  1      borrow-out (unsigned a < b + bin)
//   ovf    out  1      signed two's-complement overflow
// ============================================================================
module bit_serial_subtractor_module #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_busy;
  logic             w_done;

  // Operand shift registers (consumed from the LSB end) and the partial
  // result, which fills from the MSB end so it is aligned after WIDTH shifts.
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_part;
  logic             r_borrow;
  logic [CNT_W-1:0] r_count;

  // Operand sign bits are shifted out of the operand registers during the
  // operation, so they are kept separately for the overflow decision.
  logic             r_a_msb;
  logic             r_b_msb;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  // Full-subtractor cell
  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_part_next;
  logic             w_last;

  assign w_a0        = r_a_sh[0];
  assign w_b0        = r_b_sh[0];
  assign w_d         = w_a0 ^ w_b0 ^ r_borrow;
  assign w_br_next   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
  assign w_part_next = {w_d, r_part[WIDTH-1:1]};
  assign w_last      = (r_count == c_last_count);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_part   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_part   <= '0;
            r_borrow <= bin;
            r_count  <= '0;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
          end
        end
        S_SHIFT: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_part   <= w_part_next;
          r_borrow <= w_br_next;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            // The bit computed on this final edge is the result sign bit.
            r_diff <= w_part_next;
            r_bout <= w_br_next;
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_subtractor_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_subtractor_module
// Description : Self-checking bench for bit_serial_subtractor_module with a
//               plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_subtractor_module;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_pass;
  int n_total;

  bit_serial_subtractor_module #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {ovf, bout, diff} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic ibin);
    int ua;
    int ub;
    int ur;
    int sa;
    int sb;
    int sr;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    ua = int'(ia);
    ub = int'(ib);
    ur = ua - ub - int'(ibin);
    d  = ur[W-1:0];
    bo = (ur < 0);
    sa = ia[W-1] ? ua - (1 << W) : ua;
    sb = ib[W-1] ? ub - (1 << W) : ub;
    sr = sa - sb - int'(ibin);
    ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return {ov, bo, d};
  endfunction

  // Runs one operation starting in an idle cycle; returns after the done
  // cycle, positioned in the following idle cycle. Operand inputs are
  // scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output logic [W+1:0] res, output int busy_cyc,
                       output logic done_seen, output int overlap);
    busy_cyc = 0;
    overlap  = 0;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    while (busy && busy_cyc < 3 * W) begin
      if (done) overlap++;
      busy_cyc++;
      @(posedge clk); #1;
    end
    done_seen = done;
    if (busy && done) overlap++;
    res = {ovf, bout, diff};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = '1; b = '0; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, diff, bout, ovf} !== '0)
      $display("FAIL reset_state got busy=%b done=%b diff=%b bout=%b ovf=%b want all 0",
               busy, done, diff, bout, ovf);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin);
    logic [W+1:0] res;
    logic [W+1:0] exp;
    int bc;
    logic ds;
    int ovl;
    exp = model(ia, ib, ibin);
    do_op(ia, ib, ibin, res, bc, ds, ovl);
    n_total++;
    if (res !== exp)
      $display("FAIL %s a=%b b=%b bin=%b got ovf,bout,diff=%b want %b", name, ia, ib, ibin, res, exp);
    else n_pass++;
    n_total++;
    if (bc !== W || ds !== 1'b1 || ovl !== 0)
      $display("FAIL %s_timing got busy_cycles=%0d done=%b overlap=%0d want %0d 1 0",
               name, bc, ds, ovl, W);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W+1:0] res;
    int bc;
    logic ds;
    int ovl;
    // Hand-derived expectations from the specification examples.
    do_op(4'b0111, 4'b0011, 1'b0, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b0, 1'b0, 4'b0100} || bc !== 4 || ds !== 1'b1)
      $display("FAIL dir_7m3 got res=%b busy=%0d done=%b want 000100 4 1", res, bc, ds);
    else n_pass++;
    do_op(4'b0011, 4'b0101, 1'b0, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b0, 1'b1, 4'b1110}) $display("FAIL dir_3m5 got %b want 011110", res);
    else n_pass++;
    do_op(4'b1000, 4'b0001, 1'b0, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b1, 1'b0, 4'b0111}) $display("FAIL dir_ovf_neg got %b want 100111", res);
    else n_pass++;
    do_op(4'b0111, 4'b1111, 1'b0, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b1, 1'b1, 4'b1000}) $display("FAIL dir_ovf_pos got %b want 111000", res);
    else n_pass++;
    do_op(4'b0000, 4'b0000, 1'b1, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b0, 1'b1, 4'b1111}) $display("FAIL dir_0m0m1 got %b want 011111", res);
    else n_pass++;
    do_op(4'b1111, 4'b1111, 1'b1, res, bc, ds, ovl);
    n_total++;
    if (res !== {1'b0, 1'b1, 4'b1111}) $display("FAIL dir_fmfm1 got %b want 011111", res);
    else n_pass++;
    va = 4'b1000; vb = 4'b0111;
    check_op("dir_min_minus_max", va, vb, 1'b1);
    // Results must hold while idle.
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({ovf, bout, diff} !== model(va, vb, 1'b1))
      $display("FAIL hold_idle got %b want %b", {ovf, bout, diff}, model(va, vb, 1'b1));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      check_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    // do_op returns in the first idle cycle, so these starts are issued
    // at the earliest legal point.
    for (int i = 0; i < 6; i++) begin
      check_op("b2b", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_start_held();
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         dbin;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic         pbin;
    logic [W-1:0] held;
    logic         prev_busy;
    logic         have_pending;
    int           last_acc;
    int           n_done;
    held = diff;
    prev_busy = busy;
    have_pending = 1'b0;
    last_acc = -1;
    n_done = 0;
    pa = '0; pb = '0; pbin = 1'b0;
    for (int cyc = 0; cyc < 5 * (W + 2); cyc++) begin
      da = W'($urandom); db = W'($urandom); dbin = 1'($urandom);
      a = da; b = db; bin = dbin; start = 1'b1;
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        pa = da; pb = db; pbin = dbin; have_pending = 1'b1;
        if (last_acc >= 0) begin
          n_total++;
          if (cyc - last_acc !== W + 2)
            $display("FAIL held_spacing got %0d cycles want %0d", cyc - last_acc, W + 2);
          else n_pass++;
        end
        last_acc = cyc;
      end
      if (done) begin
        n_done++;
        n_total++;
        if (!have_pending || {ovf, bout, diff} !== model(pa, pb, pbin))
          $display("FAIL held_result a=%b b=%b bin=%b got %b want %b",
                   pa, pb, pbin, {ovf, bout, diff}, model(pa, pb, pbin));
        else n_pass++;
        have_pending = 1'b0;
        held = diff;
      end else if (diff !== held) begin
        n_total++;
        $display("FAIL held_stable got diff=%b want %b", diff, held);
      end
      if (busy && done) begin
        n_total++;
        $display("FAIL held_overlap got busy=1 done=1 want not both");
      end
      prev_busy = busy;
    end
    n_total++;
    if (n_done !== 5) $display("FAIL held_done_count got %0d want 5", n_done);
    else n_pass++;
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op();
    int extra;
    a = 4'b0110; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_pre_busy got %b want 1", busy);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_total++;
    if ({busy, done, diff, bout, ovf} !== '0)
      $display("FAIL mid_reset got busy=%b done=%b diff=%b bout=%b ovf=%b want all 0",
               busy, done, diff, bout, ovf);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL mid_no_done got %0d active cycles want 0", extra);
    else n_pass++;
    check_op("mid_fresh", 4'b0101, 4'b1010, 1'b1);
  endtask

  task automatic test_reset_with_start();
    int act;
    rst_n = 1'b0; start = 1'b1; a = 4'b1100; b = 4'b0011; bin = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    act = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (busy || done) act++;
      @(posedge clk); #1;
    end
    n_total++;
    if (act !== 0) $display("FAIL rst_start_dropped got %0d active cycles want 0", act);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_held();
    test_reset_mid_op();
    test_reset_with_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
